// File: rtl/expr_emitter_pkg.sv
// Shared constants and encodings for the expression emitter: ASCII codes,
// FSM state encoding and operator encoding.
package expr_emitter_pkg;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_NINE = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        OP    = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/expr_emitter_if.sv
// Command and byte-stream bundle of the expression emitter. The master side
// issues commands and consumes characters; the slave side is the emitter.
interface expr_emitter_if #(
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = 4
);
    import expr_emitter_pkg::*;

    logic                   start;
    logic [CNT_W-1:0]       n_terms;
    logic [4*MAX_TERMS-1:0] digits;
    logic [MAX_TERMS-2:0]   ops;
    logic                   out_ready;
    logic [7:0]             out_char;
    logic                   out_valid;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        output start, n_terms, digits, ops, out_ready,
        input  out_char, out_valid, out_last, busy, done, err
    );

    modport slave (
        input  start, n_terms, digits, ops, out_ready,
        output out_char, out_valid, out_last, busy, done, err
    );

endinterface

// File: rtl/expr_term_sel.sv
// Character decoder: picks the current operand or operator from the latched
// expression and converts it to ASCII. Outputs are zero outside DIGIT/OP.
module expr_term_sel
    import expr_emitter_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = 4,
    parameter int IDX_W     = $clog2(MAX_TERMS)
) (
    input  state_t                 state,
    input  logic [IDX_W-1:0]       idx,
    input  logic [CNT_W-1:0]       n_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    output logic [7:0]             out_char,
    output logic                   out_last
);

    logic [MAX_TERMS-1:0] ops_ext;
    logic [3:0]           digit_raw;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Padding keeps the variable index in range for every idx value.
    assign ops_ext   = {1'b0, ops};
    assign digit_raw = digits[4*idx +: 4];

    always_comb begin
        out_char = 8'h00;
        out_last = 1'b0;
        case (state)
            DIGIT: begin
                out_char = CH_ZERO + {4'h0, clamp_digit(digit_raw)};
                out_last = (CNT_W'(idx) == (n_terms - CNT_W'(1)));
            end
            OP: begin
                out_char = (ops_ext[idx] == OP_MUL) ? CH_STAR : CH_PLUS;
            end
            default: begin
                out_char = 8'h00;
                out_last = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/expr_emitter.sv
// Expression emitter: latches an operand/operator list on start and streams
// it as ASCII digit((+|*)digit)* over a valid/ready handshake.
module expr_emitter
    import expr_emitter_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = 4
) (
    input  logic          clk,
    input  logic          clr,
    expr_emitter_if.slave bus
);

    localparam int IDX_W = $clog2(MAX_TERMS);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       n_q;
    logic [4*MAX_TERMS-1:0] digits_q;
    logic [MAX_TERMS-2:0]   ops_q;
    logic                   vld_p1, busy_q, done_q, err_q;
    logic                   err_d, load, xfer, is_last;
    logic [7:0]             char_w;

    assign xfer = vld_p1 & bus.out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.n_terms == '0) || (bus.n_terms > CNT_W'(MAX_TERMS))) begin
                        err_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        idx_d   = '0;
                        state_d = DIGIT;
                    end
                end
            end
            DIGIT: begin
                if (xfer) state_d = is_last ? FIN : OP;
            end
            OP: begin
                if (xfer) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = DIGIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; flags are computed from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vld_p1  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_p1  <= (state_d == DIGIT) || (state_d == OP);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == FIN);
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            n_q      <= bus.n_terms;
            digits_q <= bus.digits;
            ops_q    <= bus.ops;
        end
    end

    expr_term_sel #(
        .MAX_TERMS (MAX_TERMS),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W)
    ) u_term_sel (
        .state    (state_q),
        .idx      (idx_q),
        .n_terms  (n_q),
        .digits   (digits_q),
        .ops      (ops_q),
        .out_char (char_w),
        .out_last (is_last)
    );

    assign bus.out_char  = char_w;
    assign bus.out_last  = is_last;
    assign bus.out_valid = vld_p1;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_expr_emitter.sv
// Directed bench for expr_emitter: cycle tables for the streaming cases plus
// hand-written sequences for errors, clamp, abort and input isolation.
module tb_expr_emitter;

    logic clk;
    logic clr;
    int   checks;
    int   failures;
    int   xfers;

    expr_emitter_if #(.MAX_TERMS(8), .CNT_W(4)) bus ();

    expr_emitter #(.MAX_TERMS(8), .CNT_W(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic       rdy;
        logic       vld;
        logic [7:0] ch;
        logic       last;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t       vt [22];
    logic [7:0] got [32];
    int         got_n;
    bit         got_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_expr(input logic [3:0] n, input logic [31:0] d, input logic [6:0] o);
        bus.n_terms = n;
        bus.digits  = d;
        bus.ops     = o;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    function automatic vec_t mk(input logic rdy, input logic vld, input logic [7:0] ch,
                                input logic last, input logic done, input logic busy);
        vec_t v;
        v.rdy = rdy; v.vld = vld; v.ch = ch; v.last = last; v.done = done; v.busy = busy;
        return v;
    endfunction

    // Streams with out_ready=1 until done; with disturb set, the inputs are
    // rewritten and start pulsed mid-stream and again in the done cycle.
    task automatic collect(input bit disturb);
        got_n    = 0;
        got_done = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && !got_done; c++) begin
            if (bus.out_valid && got_n < 32) begin
                got[got_n] = bus.out_char;
                got_n++;
            end
            if (bus.done) begin
                got_done = 1'b1;
                if (disturb) bus.start = 1'b1;
            end
            if (disturb && c == 1) begin
                bus.digits  = 32'h9999_9999;
                bus.ops     = 7'h7F;
                bus.n_terms = 4'd8;
                bus.start   = 1'b1;
            end
            if (disturb && c == 2) bus.start = 1'b0;
            step();
        end
        bus.start = 1'b0;
        chk("collect_done_seen", {31'b0, got_done}, 32'd1);
    endtask

    task automatic cmp_stream(input string tag, input string exp);
        chk($sformatf("%s_len", tag), got_n, exp.len());
        for (int i = 0; i < exp.len() && i < got_n; i++)
            chk($sformatf("%s_ch%0d", tag, i), {24'b0, got[i]}, {24'b0, exp[i]});
    endtask

    function automatic bit accept_ok();
        bit want_digit;
        want_digit = 1'b1;
        if (got_n == 0) return 1'b0;
        for (int i = 0; i < got_n; i++) begin
            if (want_digit) begin
                if (got[i] >= 8'h30 && got[i] <= 8'h39) want_digit = 1'b0;
                else return 1'b0;
            end else begin
                if (got[i] == 8'h2B || got[i] == 8'h2A) want_digit = 1'b1;
                else return 1'b0;
            end
        end
        return !want_digit;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        xfers    = 0;
        clr           = 1'b1;
        bus.start     = 1'b0;
        bus.n_terms   = '0;
        bus.digits    = '0;
        bus.ops       = '0;
        bus.out_ready = 1'b0;

        // "3+0*7" with ready held high, then with ready toggling 1,0,0,...
        vt[0]  = mk(1, 1, 8'h33, 0, 0, 1);
        vt[1]  = mk(1, 1, 8'h2B, 0, 0, 1);
        vt[2]  = mk(1, 1, 8'h30, 0, 0, 1);
        vt[3]  = mk(1, 1, 8'h2A, 0, 0, 1);
        vt[4]  = mk(1, 1, 8'h37, 1, 0, 1);
        vt[5]  = mk(0, 0, 8'h00, 0, 1, 1);
        vt[6]  = mk(0, 0, 8'h00, 0, 0, 0);
        vt[7]  = mk(1, 1, 8'h33, 0, 0, 1);
        vt[8]  = mk(0, 1, 8'h2B, 0, 0, 1);
        vt[9]  = mk(0, 1, 8'h2B, 0, 0, 1);
        vt[10] = mk(1, 1, 8'h2B, 0, 0, 1);
        vt[11] = mk(0, 1, 8'h30, 0, 0, 1);
        vt[12] = mk(0, 1, 8'h30, 0, 0, 1);
        vt[13] = mk(1, 1, 8'h30, 0, 0, 1);
        vt[14] = mk(0, 1, 8'h2A, 0, 0, 1);
        vt[15] = mk(0, 1, 8'h2A, 0, 0, 1);
        vt[16] = mk(1, 1, 8'h2A, 0, 0, 1);
        vt[17] = mk(0, 1, 8'h37, 1, 0, 1);
        vt[18] = mk(0, 1, 8'h37, 1, 0, 1);
        vt[19] = mk(1, 1, 8'h37, 1, 0, 1);
        vt[20] = mk(0, 0, 8'h00, 0, 1, 1);
        vt[21] = mk(0, 0, 8'h00, 0, 0, 0);

        #3;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_char",  bus.out_char,  0);
        chk("rst_last",  bus.out_last,  0);
        chk("rst_busy",  bus.busy,      0);
        chk("rst_done",  bus.done,      0);
        chk("rst_err",   bus.err,       0);
        step();
        step();
        clr = 1'b0;
        step();

        for (int i = 0; i < 22; i++) begin
            if (i == 0 || i == 7) start_expr(4'd3, 32'h0000_0703, 7'b0000010);
            chk($sformatf("row%0d_valid", i), bus.out_valid, vt[i].vld);
            chk($sformatf("row%0d_char", i),  bus.out_char,  vt[i].ch);
            chk($sformatf("row%0d_last", i),  bus.out_last,  vt[i].last);
            chk($sformatf("row%0d_done", i),  bus.done,      vt[i].done);
            chk($sformatf("row%0d_busy", i),  bus.busy,      vt[i].busy);
            if (i >= 7 && bus.out_valid && vt[i].rdy) xfers++;
            bus.out_ready = vt[i].rdy;
            step();
        end
        chk("stall_xfer_count", xfers, 5);

        // Illegal operand counts
        bus.n_terms = 4'd0;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        chk("err0_err",   bus.err,       1);
        chk("err0_valid", bus.out_valid, 0);
        chk("err0_busy",  bus.busy,      0);
        step();
        chk("err0_clear", bus.err,       0);
        chk("err0_idle",  bus.busy,      0);
        bus.n_terms = 4'd9;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        chk("err9_err",   bus.err,       1);
        chk("err9_valid", bus.out_valid, 0);
        chk("err9_busy",  bus.busy,      0);
        step();
        chk("err9_clear", bus.err,       0);

        // Single term with out-of-range digit
        bus.out_ready = 1'b0;
        start_expr(4'd1, 32'h0000_000C, 7'b0);
        chk("one_valid", bus.out_valid, 1);
        chk("one_char",  bus.out_char,  8'h39);
        chk("one_last",  bus.out_last,  1);
        bus.out_ready = 1'b1;
        step();
        chk("one_done",  bus.done,      1);
        chk("one_v0",    bus.out_valid, 0);
        step();
        chk("one_idle",  bus.busy,      0);
        chk("one_done0", bus.done,      0);

        // Abort with clr after the second transfer
        start_expr(4'd3, 32'h0000_0703, 7'b0000010);
        step();
        step();
        chk("abort_pre_char", bus.out_char, 8'h30);
        #2;
        clr = 1'b1;
        #1;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy",  bus.busy,      0);
        chk("abort_char",  bus.out_char,  0);
        step();
        chk("abort_done",  bus.done,      0);
        clr = 1'b0;
        step();
        chk("abort_done2", bus.done,      0);
        chk("abort_idle",  bus.out_valid, 0);
        start_expr(4'd2, 32'h0000_0058, 7'b0000001);
        collect(1'b0);
        cmp_stream("after_abort", "8*5");

        // Inputs changed and start pulsed while busy, and start in the done cycle
        bus.out_ready = 1'b0;
        start_expr(4'd3, 32'h0000_0703, 7'b0000010);
        collect(1'b1);
        cmp_stream("isolate", "3+0*7");
        chk("isolate_accept",   {31'b0, accept_ok()}, 1);
        chk("fin_start_busy",   bus.busy,      0);
        chk("fin_start_valid",  bus.out_valid, 0);
        step();
        chk("fin_start_idle",   bus.busy,      0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
